// File: rtl/wb_stage_reg_pkg.sv
// Shared constants and types for the MEM->WB pipeline register.
// Holds the stall/write-enable encodings and the per-cycle action type.
package wb_stage_reg_pkg;

    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam int   CNT_W         = 64;

    typedef enum logic [1:0] {
        ACT_CAPTURE,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_FLUSH
    } wb_act_e;

endpackage

// File: rtl/wb_lane_merge.sv
// Combinational lane merge: qualification, $zero masking, WAW clear,
// and youngest-wins selection of hi/lo and LLbit writes.
module wb_lane_merge
    import wb_stage_reg_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 2
) (
    input  logic [LANES-1:0]        valid,
    input  logic [LANES*ADDR_W-1:0] wd,
    input  logic [LANES-1:0]        wreg,
    input  logic [LANES*DATA_W-1:0] wdata,
    input  logic [LANES*DATA_W-1:0] hi,
    input  logic [LANES*DATA_W-1:0] lo,
    input  logic [LANES-1:0]        whilo,
    input  logic [LANES-1:0]        llbit_we,
    input  logic [LANES-1:0]        llbit_value,
    output logic [LANES-1:0]        valid_o,
    output logic [LANES*ADDR_W-1:0] wd_o,
    output logic [LANES-1:0]        wreg_o,
    output logic [LANES*DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0]       hi_o,
    output logic [DATA_W-1:0]       lo_o,
    output logic                    whilo_o,
    output logic                    llbit_we_o,
    output logic                    llbit_value_o
);

    logic [LANES-1:0] we;

    always_comb begin
        valid_o = '0;
        wd_o    = '0;
        wdata_o = '0;
        we      = '0;
        for (int i = 0; i < LANES; i++) begin
            valid_o[i] = valid[i];
            if (valid[i]) begin
                wd_o[i*ADDR_W +: ADDR_W]    = wd[i*ADDR_W +: ADDR_W];
                wdata_o[i*DATA_W +: DATA_W] = wdata[i*DATA_W +: DATA_W];
                we[i] = wreg[i] && (wd[i*ADDR_W +: ADDR_W] != '0);
            end
        end
    end

    // An older lane loses its GPR write to any younger lane hitting the same register.
    always_comb begin
        wreg_o = we;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (we[i] && we[j] &&
                    wd_o[i*ADDR_W +: ADDR_W] == wd_o[j*ADDR_W +: ADDR_W]) begin
                    wreg_o[i] = WRITE_DISABLE;
                end
            end
        end
    end

    always_comb begin
        hi_o          = '0;
        lo_o          = '0;
        whilo_o       = WRITE_DISABLE;
        llbit_we_o    = WRITE_DISABLE;
        llbit_value_o = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (valid[i] && whilo[i]) begin
                hi_o    = hi[i*DATA_W +: DATA_W];
                lo_o    = lo[i*DATA_W +: DATA_W];
                whilo_o = WRITE_ENABLE;
            end
            if (valid[i] && llbit_we[i]) begin
                llbit_we_o    = WRITE_ENABLE;
                llbit_value_o = llbit_value[i];
            end
        end
    end

endmodule

// File: rtl/wb_stage_reg.sv
// MEM->WB pipeline register with stall/flush handling and lane merge.
// Define WB_RETIRE_CNT_EN to build the 64-bit retired-instruction counter.
module wb_stage_reg
    import wb_stage_reg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int LANES   = 2,
    parameter int STALL_W = 6,
    parameter int STAGE   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    input  logic [LANES-1:0]        mem_valid,
    input  logic [LANES*ADDR_W-1:0] mem_wd,
    input  logic [LANES-1:0]        mem_wreg,
    input  logic [LANES*DATA_W-1:0] mem_wdata,
    input  logic [LANES*DATA_W-1:0] mem_hi,
    input  logic [LANES*DATA_W-1:0] mem_lo,
    input  logic [LANES-1:0]        mem_whilo,
    input  logic [LANES-1:0]        mem_llbit_we,
    input  logic [LANES-1:0]        mem_llbit_value,
    output logic [LANES-1:0]        wb_valid,
    output logic [LANES*ADDR_W-1:0] wb_wd,
    output logic [LANES-1:0]        wb_wreg,
    output logic [LANES*DATA_W-1:0] wb_wdata,
    output logic [DATA_W-1:0]       wb_hi,
    output logic [DATA_W-1:0]       wb_lo,
    output logic                    wb_whilo,
    output logic                    wb_llbit_we,
    output logic                    wb_llbit_value,
    output logic [CNT_W-1:0]        retire_cnt
);

    logic down_stall;
    logic unused_stall;
    wb_act_e act;

    assign unused_stall = ^stall;

    // The last stage has no downstream stage, so it can never be held.
    generate
        if (STAGE >= STALL_W - 1) begin : g_last
            assign down_stall = NO_STOP;
        end else begin : g_mid
            assign down_stall = stall[STAGE+1];
        end
    endgenerate

    always_comb begin
        act = ACT_HOLD;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (stall[STAGE] == STOP && down_stall == NO_STOP) begin
            act = ACT_BUBBLE;
        end else if (stall[STAGE] == NO_STOP) begin
            act = ACT_CAPTURE;
        end
    end

    logic [LANES-1:0]        m_valid;
    logic [LANES*ADDR_W-1:0] m_wd;
    logic [LANES-1:0]        m_wreg;
    logic [LANES*DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0]       m_hi;
    logic [DATA_W-1:0]       m_lo;
    logic                    m_whilo;
    logic                    m_llbit_we;
    logic                    m_llbit_value;

    wb_lane_merge #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
    ) u_merge (
        .valid         (mem_valid),
        .wd            (mem_wd),
        .wreg          (mem_wreg),
        .wdata         (mem_wdata),
        .hi            (mem_hi),
        .lo            (mem_lo),
        .whilo         (mem_whilo),
        .llbit_we      (mem_llbit_we),
        .llbit_value   (mem_llbit_value),
        .valid_o       (m_valid),
        .wd_o          (m_wd),
        .wreg_o        (m_wreg),
        .wdata_o       (m_wdata),
        .hi_o          (m_hi),
        .lo_o          (m_lo),
        .whilo_o       (m_whilo),
        .llbit_we_o    (m_llbit_we),
        .llbit_value_o (m_llbit_value)
    );

    logic [LANES-1:0]        valid_q, valid_d;
    logic [LANES*ADDR_W-1:0] wd_q, wd_d;
    logic [LANES-1:0]        wreg_q, wreg_d;
    logic [LANES*DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0]       hi_q, hi_d;
    logic [DATA_W-1:0]       lo_q, lo_d;
    logic                    whilo_q, whilo_d;
    logic                    llbit_we_q, llbit_we_d;
    logic                    llbit_value_q, llbit_value_d;

    always_comb begin
        valid_d       = valid_q;
        wd_d          = wd_q;
        wreg_d        = wreg_q;
        wdata_d       = wdata_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        whilo_d       = whilo_q;
        llbit_we_d    = llbit_we_q;
        llbit_value_d = llbit_value_q;
        unique case (act)
            ACT_FLUSH, ACT_BUBBLE: begin
                valid_d       = '0;
                wd_d          = '0;
                wreg_d        = '0;
                wdata_d       = '0;
                hi_d          = '0;
                lo_d          = '0;
                whilo_d       = WRITE_DISABLE;
                llbit_we_d    = WRITE_DISABLE;
                llbit_value_d = 1'b0;
            end
            ACT_CAPTURE: begin
                valid_d       = m_valid;
                wd_d          = m_wd;
                wreg_d        = m_wreg;
                wdata_d       = m_wdata;
                hi_d          = m_hi;
                lo_d          = m_lo;
                whilo_d       = m_whilo;
                llbit_we_d    = m_llbit_we;
                llbit_value_d = m_llbit_value;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            wd_q          <= '0;
            wreg_q        <= '0;
            wdata_q       <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            whilo_q       <= WRITE_DISABLE;
            llbit_we_q    <= WRITE_DISABLE;
            llbit_value_q <= 1'b0;
        end else begin
            valid_q       <= valid_d;
            wd_q          <= wd_d;
            wreg_q        <= wreg_d;
            wdata_q       <= wdata_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            whilo_q       <= whilo_d;
            llbit_we_q    <= llbit_we_d;
            llbit_value_q <= llbit_value_d;
        end
    end

    assign wb_valid       = valid_q;
    assign wb_wd          = wd_q;
    assign wb_wreg        = wreg_q;
    assign wb_wdata       = wdata_q;
    assign wb_hi          = hi_q;
    assign wb_lo          = lo_q;
    assign wb_whilo       = whilo_q;
    assign wb_llbit_we    = llbit_we_q;
    assign wb_llbit_value = llbit_value_q;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d, valid_pop;

    always_comb begin
        valid_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            valid_pop = valid_pop + CNT_W'(mem_valid[i]);
        end
        cnt_d = cnt_q;
        if (act == ACT_CAPTURE) begin
            cnt_d = cnt_q + valid_pop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign retire_cnt = cnt_q;
`else
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage_reg.sv
// Self-checking bench for wb_stage_reg (LANES=2, STAGE=4, STALL_W=6).
// Expected results are queued when driven and compared one cycle later.
module tb_wb_stage_reg;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [1:0]  mem_valid;
    logic [9:0]  mem_wd;
    logic [1:0]  mem_wreg;
    logic [63:0] mem_wdata;
    logic [63:0] mem_hi;
    logic [63:0] mem_lo;
    logic [1:0]  mem_whilo;
    logic [1:0]  mem_llbit_we;
    logic [1:0]  mem_llbit_value;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_wd;
    logic [1:0]  wb_wreg;
    logic [63:0] wb_wdata;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_whilo;
    logic        wb_llbit_we;
    logic        wb_llbit_value;
    logic [63:0] retire_cnt;

    wb_stage_reg dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .mem_valid       (mem_valid),
        .mem_wd          (mem_wd),
        .mem_wreg        (mem_wreg),
        .mem_wdata       (mem_wdata),
        .mem_hi          (mem_hi),
        .mem_lo          (mem_lo),
        .mem_whilo       (mem_whilo),
        .mem_llbit_we    (mem_llbit_we),
        .mem_llbit_value (mem_llbit_value),
        .wb_valid        (wb_valid),
        .wb_wd           (wb_wd),
        .wb_wreg         (wb_wreg),
        .wb_wdata        (wb_wdata),
        .wb_hi           (wb_hi),
        .wb_lo           (wb_lo),
        .wb_whilo        (wb_whilo),
        .wb_llbit_we     (wb_llbit_we),
        .wb_llbit_value  (wb_llbit_value),
        .retire_cnt      (retire_cnt)
    );

    typedef struct packed {
        logic [1:0]  valid;
        logic [9:0]  wd;
        logic [1:0]  wreg;
        logic [63:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        whilo;
        logic        llwe;
        logic        llval;
        logic [63:0] cnt;
    } obs_t;

    obs_t exp_q[$];
    obs_t prev;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t s;
        s.valid = wb_valid;
        s.wd    = wb_wd;
        s.wreg  = wb_wreg;
        s.wdata = wb_wdata;
        s.hi    = wb_hi;
        s.lo    = wb_lo;
        s.whilo = wb_whilo;
        s.llwe  = wb_llbit_we;
        s.llval = wb_llbit_value;
        s.cnt   = retire_cnt;
        return s;
    endfunction

    function automatic obs_t merge_model();
        obs_t m;
        logic w0, w1;
        m = '0;
        if (mem_valid[0]) begin
            m.wd[4:0]     = mem_wd[4:0];
            m.wdata[31:0] = mem_wdata[31:0];
        end
        if (mem_valid[1]) begin
            m.wd[9:5]      = mem_wd[9:5];
            m.wdata[63:32] = mem_wdata[63:32];
        end
        m.valid = mem_valid;
        w0 = mem_valid[0] & mem_wreg[0] & (mem_wd[4:0] != 5'd0);
        w1 = mem_valid[1] & mem_wreg[1] & (mem_wd[9:5] != 5'd0);
        if (w0 && w1 && mem_wd[4:0] == mem_wd[9:5]) w0 = 1'b0;
        m.wreg = {w1, w0};
        if (mem_valid[1] && mem_whilo[1]) begin
            m.hi = mem_hi[63:32];
            m.lo = mem_lo[63:32];
            m.whilo = 1'b1;
        end else if (mem_valid[0] && mem_whilo[0]) begin
            m.hi = mem_hi[31:0];
            m.lo = mem_lo[31:0];
            m.whilo = 1'b1;
        end
        if (mem_valid[1] && mem_llbit_we[1]) begin
            m.llwe  = 1'b1;
            m.llval = mem_llbit_value[1];
        end else if (mem_valid[0] && mem_llbit_we[0]) begin
            m.llwe  = 1'b1;
            m.llval = mem_llbit_value[0];
        end
        return m;
    endfunction

    // Queue the expected register contents for the current inputs and clock once.
    task automatic apply();
        obs_t e;
        if (rst) begin
            e = '0;
        end else if (flush || (stall[4] && !stall[5])) begin
            e = '0;
            e.cnt = prev.cnt;
        end else if (!stall[4]) begin
            e = merge_model();
`ifdef WB_RETIRE_CNT_EN
            e.cnt = prev.cnt + 64'(mem_valid[0]) + 64'(mem_valid[1]);
`else
            e.cnt = 64'd0;
`endif
        end else begin
            e = prev;
        end
        prev = e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        mem_valid       = 2'($urandom);
        mem_wd          = 10'($urandom);
        mem_wreg        = 2'($urandom);
        mem_wdata       = {$urandom, $urandom};
        mem_hi          = {$urandom, $urandom};
        mem_lo          = {$urandom, $urandom};
        mem_whilo       = 2'($urandom);
        mem_llbit_we    = 2'($urandom);
        mem_llbit_value = 2'($urandom);
    endtask

    task automatic clear_inputs();
        mem_valid = '0; mem_wd = '0; mem_wreg = '0; mem_wdata = '0;
        mem_hi = '0; mem_lo = '0; mem_whilo = '0;
        mem_llbit_we = '0; mem_llbit_value = '0;
    endtask

    task automatic test_reset();
        obs_t e, g;
        rst = 1'b1; flush = 1'b0; stall = '0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            flush = 1'(i);
            apply();
            e = exp_q.pop_front();
            g = sample();
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL reset got=%h exp=%h", g, e);
            end else passes++;
            checks++;
            if (retire_cnt !== 64'd0 || wb_valid !== 2'b00) begin
                fails++;
                $display("FAIL reset_cnt got=%h exp=0", retire_cnt);
            end else passes++;
        end
        rst = 1'b0; flush = 1'b0;
    endtask

    task automatic test_dual_write();
        obs_t e, g;
        logic [63:0] c0;
        c0 = prev.cnt;
        clear_inputs();
        stall = '0; flush = 1'b0;
        mem_valid = 2'b11; mem_wd = {5'd3, 5'd7}; mem_wreg = 2'b11;
        mem_wdata = {32'hCAFE0003, 32'hBEEF0007};
        apply();
        e = exp_q.pop_front();
        g = sample();
        checks++;
        if (g !== e) begin
            fails++;
            $display("FAIL dual_write got=%h exp=%h", g, e);
        end else passes++;
        checks++;
        if (wb_wreg !== 2'b11 || wb_wd !== {5'd3, 5'd7}) begin
            fails++;
            $display("FAIL dual_wreg got=%b/%h exp=11/%h", wb_wreg, wb_wd, {5'd3, 5'd7});
        end else passes++;
`ifdef WB_RETIRE_CNT_EN
        checks++;
        if (retire_cnt !== c0 + 64'd2) begin
            fails++;
            $display("FAIL dual_cnt got=%0d exp=%0d", retire_cnt, c0 + 64'd2);
        end else passes++;
`endif
    endtask

    task automatic test_waw();
        obs_t e, g;
        clear_inputs();
        mem_valid = 2'b11; mem_wd = {5'd9, 5'd9}; mem_wreg = 2'b11;
        mem_wdata = {32'h2222, 32'h1111};
        apply();
        e = exp_q.pop_front();
        g = sample();
        checks++;
        if (g !== e) begin
            fails++;
            $display("FAIL waw got=%h exp=%h", g, e);
        end else passes++;
        checks++;
        if (wb_wreg !== 2'b10 || wb_wdata[63:32] !== 32'h2222) begin
            fails++;
            $display("FAIL waw_lane got=%b/%h exp=10/00002222", wb_wreg, wb_wdata[63:32]);
        end else passes++;
    endtask

    task automatic test_hilo_zero();
        obs_t e, g;
        clear_inputs();
        mem_valid = 2'b11; mem_wd = {5'd4, 5'd0}; mem_wreg = 2'b11;
        mem_whilo = 2'b11; mem_hi = {32'hB, 32'hA}; mem_lo = {32'h5, 32'h6};
        mem_llbit_we = 2'b11; mem_llbit_value = 2'b01;
        apply();
        e = exp_q.pop_front();
        g = sample();
        checks++;
        if (g !== e) begin
            fails++;
            $display("FAIL hilo got=%h exp=%h", g, e);
        end else passes++;
        checks++;
        if (wb_hi !== 32'hB || wb_lo !== 32'h5 || wb_whilo !== 1'b1 || wb_wreg !== 2'b10) begin
            fails++;
            $display("FAIL hilo_sel got=%h/%h/%b/%b exp=b/5/1/10", wb_hi, wb_lo, wb_whilo, wb_wreg);
        end else passes++;
        checks++;
        if (wb_llbit_we !== 1'b1 || wb_llbit_value !== 1'b0) begin
            fails++;
            $display("FAIL llbit got=%b/%b exp=1/0", wb_llbit_we, wb_llbit_value);
        end else passes++;
        // Lane 0 only, invalid lane 1 must not contribute.
        mem_valid = 2'b01; mem_wd = {5'd4, 5'd12};
        apply();
        e = exp_q.pop_front();
        g = sample();
        checks++;
        if (g !== e) begin
            fails++;
            $display("FAIL hilo_lane0 got=%h exp=%h", g, e);
        end else passes++;
    endtask

    task automatic test_stall();
        obs_t e, g, held;
        clear_inputs();
        stall = '0;
        mem_valid = 2'b11; mem_wd = {5'd1, 5'd2}; mem_wreg = 2'b11;
        mem_wdata = {32'h0A0A0A0A, 32'h0B0B0B0B};
        mem_whilo = 2'b01; mem_hi = {32'h0, 32'h77};
        apply();
        e = exp_q.pop_front();
        held = sample();
        checks++;
        if (held !== e) begin
            fails++;
            $display("FAIL stall_pre got=%h exp=%h", held, e);
        end else passes++;
        stall = 6'b110000;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            apply();
            e = exp_q.pop_front();
            g = sample();
            checks++;
            if (g !== e || g !== held) begin
                fails++;
                $display("FAIL hold got=%h exp=%h", g, e);
            end else passes++;
        end
        stall = 6'b010000;
        rand_inputs();
        apply();
        e = exp_q.pop_front();
        g = sample();
        checks++;
        if (g !== e || wb_valid !== 2'b00 || retire_cnt !== held.cnt) begin
            fails++;
            $display("FAIL bubble got=%h exp=%h", g, e);
        end else passes++;
        stall = 6'b100000;
        apply();
        e = exp_q.pop_front();
        g = sample();
        checks++;
        if (g !== e) begin
            fails++;
            $display("FAIL down_only got=%h exp=%h", g, e);
        end else passes++;
    endtask

    task automatic test_flush();
        obs_t e, g;
        logic [63:0] c0;
        c0 = prev.cnt;
        stall = '0; flush = 1'b1;
        rand_inputs();
        mem_valid = 2'b11;
        apply();
        e = exp_q.pop_front();
        g = sample();
        checks++;
        if (g !== e || wb_valid !== 2'b00 || retire_cnt !== c0) begin
            fails++;
            $display("FAIL flush got=%h exp=%h", g, e);
        end else passes++;
        stall = 6'b110000;
        apply();
        e = exp_q.pop_front();
        g = sample();
        checks++;
        if (g !== e) begin
            fails++;
            $display("FAIL flush_stall got=%h exp=%h", g, e);
        end else passes++;
        flush = 1'b0;
    endtask

    task automatic test_back_to_back();
        obs_t e, g;
        logic [5:0] stall_tab [4];
        stall_tab[0] = 6'b000000;
        stall_tab[1] = 6'b010000;
        stall_tab[2] = 6'b110000;
        stall_tab[3] = 6'b100000;
        for (int i = 0; i < 60; i++) begin
            rand_inputs();
            stall = stall_tab[$urandom_range(0, 3)];
            if ($urandom_range(0, 2) == 0) stall = 6'b000000;
            flush = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) mem_wd[9:5] = mem_wd[4:0];
            apply();
            e = exp_q.pop_front();
            g = sample();
            checks++;
            if (g !== e) begin
                fails++;
                $display("FAIL b2b[%0d] got=%h exp=%h", i, g, e);
            end else passes++;
        end
        flush = 1'b0;
    endtask

    initial begin
        prev = '0;
        rst = 1'b1; flush = 1'b0; stall = '0;
        clear_inputs();
        test_reset();
        test_dual_write();
        test_waw();
        test_hilo_zero();
        test_stall();
        test_flush();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
        end else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
